// File: rtl/uart_config_regfile.sv
// rtl/uart_config_regfile.sv - UART configuration register file with staged frame config and atomic divisor commit
//
// Host-addressed registers (STR, LDVR, UDVR, FSR, CTR, ISR, RXR, TXR) with separate
// write/read buses and registered read data. Frame configuration changes are handed
// to the configuration controller via cfg_req_o/cfg_ack_i/cfg_done_i. The baud divisor
// is committed atomically while TX and RX are idle.
// Optional feature macro: CONFIG_TIMEOUT_EN (abort a stalled configuration handshake).
//
// Ports:
//   clk_i, rst_n_i                          clock, asynchronous active-low reset
//   write_i, read_i, address_i, wdata_i     host access (write wins when both strobes are high)
//   rdata_o, rdata_valid_o                  registered read data and its one-cycle valid
//   data_width_o, parity_mode_o, stop_bits_o, tx_dsm_o, rx_dsm_o   active frame configuration
//   cfg_req_o, cfg_ack_i, cfg_done_i        configuration controller handshake
//   tx_idle_i, rx_idle_i                    transceiver idle, gates the divisor commit
//   divisor_o, bd_gen_reset_o               active divisor and commit pulse
//   tx_fifo_full_i, rx_fifo_empty_i         FIFO status
//   rx_fifo_threshold_o, comm_mode_o        FSR threshold, CTR communication mode
//   rx_data_i, rx_fifo_read_o               RX FIFO head and pop
//   tx_data_o, tx_fifo_write_o              TX FIFO data and push
//   int_event_i, int_o                      interrupt events and combined interrupt

module uart_config_regfile #(
    parameter int          BUS_WIDTH      = 8,
    parameter logic [15:0] STD_DIVISOR    = 16'd325,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 write_i,
    input  logic                 read_i,
    input  logic [2:0]           address_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    output logic [BUS_WIDTH-1:0] rdata_o,
    output logic                 rdata_valid_o,
    output logic [1:0]           data_width_o,
    output logic [1:0]           parity_mode_o,
    output logic [1:0]           stop_bits_o,
    output logic                 tx_dsm_o,
    output logic                 rx_dsm_o,
    output logic                 cfg_req_o,
    input  logic                 cfg_ack_i,
    input  logic                 cfg_done_i,
    input  logic                 tx_idle_i,
    input  logic                 rx_idle_i,
    output logic [15:0]          divisor_o,
    output logic                 bd_gen_reset_o,
    input  logic                 tx_fifo_full_i,
    input  logic                 rx_fifo_empty_i,
    output logic [5:0]           rx_fifo_threshold_o,
    input  logic [7:0]           rx_data_i,
    output logic                 rx_fifo_read_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_fifo_write_o,
    input  logic [3:0]           int_event_i,
    output logic [1:0]           comm_mode_o,
    output logic                 int_o
);

    // Standard frame configuration: 8 data bits, no parity, 1 stop bit.
    localparam logic [1:0] STD_DATA_WIDTH  = 2'b11;
    localparam logic [1:0] STD_PARITY_MODE = 2'b00;
    localparam logic [1:0] STD_STOP_BITS   = 2'b00;
    localparam logic [1:0] STD_COMM_MODE   = 2'b00;
    localparam logic [5:0] STD_CFG = {STD_STOP_BITS, STD_PARITY_MODE, STD_DATA_WIDTH};

    localparam logic [2:0] A_STR = 3'd0, A_LDVR = 3'd1, A_UDVR = 3'd2, A_FSR = 3'd3;
    localparam logic [2:0] A_CTR = 3'd4, A_ISR = 3'd5, A_RXR = 3'd6, A_TXR = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} cfg_state_t;
    cfg_state_t state_q, state_d;

    logic [15:0] wdata16;
    logic        rd_en;
    logic        wr_str, wr_ldvr, wr_udvr, wr_fsr, wr_ctr, wr_isr, wr_txr, stdc;
    logic        done_q, done_rise, str_start, cfg_commit, cfg_abort;
    logic        tmo_expire, tmo_q;

    // {SBID, PMID, DWID}
    logic [5:0]  cfg_act_q, cfg_stg_q;
    logic        tdsm_q, rdsm_q;
    logic [15:0] div_q, div_stg_q;
    logic        div_armed_q, bd_pulse_q;
    logic [5:0]  thr_q;
    logic [1:0]  com_q;
    logic        enreq_q, txf_q, rxe_q;
    logic [3:0]  int_en_q, int_pend_q;
    logic [7:0]  txr_q;
    logic [15:0] rd_val;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic        rvalid_q;

    assign wdata16 = 16'(wdata_i);
    assign rd_en   = read_i & ~write_i;
    assign wr_str  = write_i && (address_i == A_STR);
    assign wr_ldvr = write_i && (address_i == A_LDVR);
    assign wr_udvr = write_i && (address_i == A_UDVR);
    assign wr_fsr  = write_i && (address_i == A_FSR);
    assign wr_ctr  = write_i && (address_i == A_CTR);
    assign wr_isr  = write_i && (address_i == A_ISR);
    assign wr_txr  = write_i && (address_i == A_TXR);
    assign stdc    = wr_ctr & wdata_i[0];

    assign done_rise = cfg_done_i & ~done_q;
    assign str_start = wr_str && (state_q == ST_IDLE) && enreq_q && (wdata_i[5:0] != cfg_stg_q);

    always_comb begin
        state_d    = state_q;
        cfg_commit = 1'b0;
        cfg_abort  = 1'b0;
        case (state_q)
            ST_IDLE: if (str_start) state_d = ST_REQ;
            // An ack arriving together with the done edge skips WAIT entirely.
            ST_REQ: begin
                if (cfg_ack_i && done_rise) begin
                    state_d    = ST_IDLE;
                    cfg_commit = 1'b1;
                end else if (cfg_ack_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    state_d    = ST_IDLE;
                    cfg_commit = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_expire && (state_d == state_q)) begin
            state_d   = ST_IDLE;
            cfg_abort = 1'b1;
        end
        // Standard-config request overrides any handshake in flight.
        if (stdc) begin
            state_d    = ST_IDLE;
            cfg_commit = 1'b0;
            cfg_abort  = 1'b0;
        end
    end

`ifdef CONFIG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    assign tmo_expire = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (state_d != state_q)
                tmo_cnt_q <= '0;
            else if (state_q != ST_IDLE)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (cfg_abort)
                tmo_q <= 1'b1;
            else if (wr_ctr && wdata_i[1])
                tmo_q <= 1'b0;
        end
    end
`else
    // Without the timeout feature the handshake waits forever; TIMEOUT_CYCLES has no effect.
    assign tmo_expire = (TIMEOUT_CYCLES < 0);
    assign tmo_q      = 1'b0;
`endif

    always_comb begin
        rd_val = 16'h0000;
        case (address_i)
            A_STR:  rd_val = {8'h00, tdsm_q, rdsm_q, cfg_stg_q};
            A_LDVR: rd_val = (BUS_WIDTH == 16) ? div_stg_q : {8'h00, div_stg_q[7:0]};
            A_UDVR: rd_val = {8'h00, div_stg_q[15:8]};
            A_FSR:  rd_val = {8'h00, txf_q, rxe_q, thr_q};
            A_CTR:  rd_val = {8'h00, state_q == ST_IDLE, int_o, com_q, enreq_q,
                              state_q != ST_IDLE, tmo_q, 1'b0};
            A_ISR:  rd_val = {8'h00, int_en_q, int_pend_q};
            A_RXR:  rd_val = rx_fifo_empty_i ? 16'h0000 : {8'h00, rx_data_i};
            A_TXR:  rd_val = {8'h00, txr_q};
            default: rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            cfg_act_q   <= STD_CFG;
            cfg_stg_q   <= STD_CFG;
            tdsm_q      <= 1'b0;
            rdsm_q      <= 1'b0;
            div_q       <= STD_DIVISOR;
            div_stg_q   <= STD_DIVISOR;
            div_armed_q <= 1'b0;
            bd_pulse_q  <= 1'b0;
            thr_q       <= 6'd0;
            com_q       <= STD_COMM_MODE;
            enreq_q     <= 1'b1;
            txf_q       <= 1'b0;
            rxe_q       <= 1'b0;
            int_en_q    <= 4'b1111;
            int_pend_q  <= 4'b0000;
            txr_q       <= 8'h00;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= cfg_done_i;

            if (stdc) begin
                cfg_act_q <= STD_CFG;
                cfg_stg_q <= STD_CFG;
            end else begin
                if (cfg_commit) cfg_act_q <= cfg_stg_q;
                if (cfg_abort)
                    cfg_stg_q <= cfg_act_q;
                else if (wr_str && (state_q == ST_IDLE))
                    cfg_stg_q <= wdata_i[5:0];
            end
            if (wr_str) begin
                tdsm_q <= wdata_i[7];
                rdsm_q <= wdata_i[6];
            end

            // A divisor write in the same cycle defers the commit, so a burst of
            // writes while armed yields one commit of the final staging value.
            bd_pulse_q <= 1'b0;
            if (stdc) begin
                div_q       <= STD_DIVISOR;
                div_stg_q   <= STD_DIVISOR;
                div_armed_q <= 1'b0;
                bd_pulse_q  <= 1'b1;
            end else if (wr_ldvr) begin
                if (BUS_WIDTH == 16) begin
                    div_stg_q   <= wdata16;
                    div_armed_q <= 1'b1;
                end else begin
                    div_stg_q[7:0] <= wdata16[7:0];
                end
            end else if (wr_udvr) begin
                div_stg_q[15:8] <= wdata16[7:0];
                div_armed_q     <= 1'b1;
            end else if (div_armed_q && tx_idle_i && rx_idle_i) begin
                div_q       <= div_stg_q;
                div_armed_q <= 1'b0;
                bd_pulse_q  <= 1'b1;
            end

            if (wr_ctr) begin
                com_q   <= wdata_i[5:4];
                enreq_q <= wdata_i[3];
            end
            txf_q <= tx_fifo_full_i;
            rxe_q <= rx_fifo_empty_i;
            if (wr_fsr) thr_q <= wdata_i[5:0];

            // Set has priority over a W1C clear of the same bit; set uses the old enables.
            int_pend_q <= (int_pend_q & ~(wr_isr ? wdata_i[3:0] : 4'b0000)) | (int_event_i & int_en_q);
            if (wr_isr) int_en_q <= wdata_i[7:4];

            if (wr_txr) txr_q <= wdata_i[7:0];

            rdata_q  <= rd_en ? rd_val[BUS_WIDTH-1:0] : '0;
            rvalid_q <= rd_en;
        end
    end

    assign rdata_o             = rdata_q;
    assign rdata_valid_o       = rvalid_q;
    assign data_width_o        = cfg_act_q[1:0];
    assign parity_mode_o       = cfg_act_q[3:2];
    assign stop_bits_o         = cfg_act_q[5:4];
    assign tx_dsm_o            = tdsm_q;
    assign rx_dsm_o            = rdsm_q;
    assign cfg_req_o           = (state_q == ST_REQ);
    assign divisor_o           = div_q;
    assign bd_gen_reset_o      = bd_pulse_q;
    assign rx_fifo_threshold_o = thr_q;
    assign rx_fifo_read_o      = rd_en && (address_i == A_RXR) && !rx_fifo_empty_i;
    assign tx_data_o           = wdata_i[7:0];
    assign tx_fifo_write_o     = wr_txr && !tx_fifo_full_i;
    assign comm_mode_o         = com_q;
    assign int_o               = |int_pend_q;

endmodule

// File: tb/tb_uart_config_regfile.sv
// tb/tb_uart_config_regfile.sv - self-checking bench for uart_config_regfile against a behavioural model

module tb_uart_config_regfile;

    localparam int          BW      = 8;
    localparam logic [15:0] STD_DIV = 16'd325;
    localparam int          TMO_CYC = 64;
    localparam logic [5:0]  STD_CFG = 6'b00_00_11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_i, read_i;
    logic [2:0]  address_i;
    logic [7:0]  wdata_i;
    logic [7:0]  rdata_o;
    logic        rdata_valid_o;
    logic [1:0]  data_width_o, parity_mode_o, stop_bits_o;
    logic        tx_dsm_o, rx_dsm_o;
    logic        cfg_req_o, cfg_ack_i, cfg_done_i;
    logic        tx_idle_i, rx_idle_i;
    logic [15:0] divisor_o;
    logic        bd_gen_reset_o;
    logic        tx_fifo_full_i, rx_fifo_empty_i;
    logic [5:0]  rx_fifo_threshold_o;
    logic [7:0]  rx_data_i;
    logic        rx_fifo_read_o;
    logic [7:0]  tx_data_o;
    logic        tx_fifo_write_o;
    logic [3:0]  int_event_i;
    logic [1:0]  comm_mode_o;
    logic        int_o;

    int n_vec = 0;
    int n_err = 0;

    uart_config_regfile #(
        .BUS_WIDTH(BW), .STD_DIVISOR(STD_DIV), .TIMEOUT_CYCLES(TMO_CYC)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .write_i(write_i), .read_i(read_i), .address_i(address_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .data_width_o(data_width_o), .parity_mode_o(parity_mode_o), .stop_bits_o(stop_bits_o),
        .tx_dsm_o(tx_dsm_o), .rx_dsm_o(rx_dsm_o),
        .cfg_req_o(cfg_req_o), .cfg_ack_i(cfg_ack_i), .cfg_done_i(cfg_done_i),
        .tx_idle_i(tx_idle_i), .rx_idle_i(rx_idle_i),
        .divisor_o(divisor_o), .bd_gen_reset_o(bd_gen_reset_o),
        .tx_fifo_full_i(tx_fifo_full_i), .rx_fifo_empty_i(rx_fifo_empty_i),
        .rx_fifo_threshold_o(rx_fifo_threshold_o),
        .rx_data_i(rx_data_i), .rx_fifo_read_o(rx_fifo_read_o),
        .tx_data_o(tx_data_o), .tx_fifo_write_o(tx_fifo_write_o),
        .int_event_i(int_event_i), .comm_mode_o(comm_mode_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    // Reference model state. m_phase: 0 no change pending, 1 requesting, 2 waiting for done.
    logic [5:0]  m_act, m_stg, m_thr;
    logic        m_tdsm, m_rdsm, m_armed, m_bd, m_enreq, m_tmo, m_txf, m_rxe, m_done_prev, m_rvalid;
    logic [15:0] m_div, m_dstg;
    logic [1:0]  m_com;
    logic [3:0]  m_en, m_pend;
    logic [7:0]  m_txr, m_rdata;
    int          m_phase, m_dwell;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = STD_CFG; m_stg = STD_CFG; m_tdsm = 0; m_rdsm = 0;
        m_div = STD_DIV; m_dstg = STD_DIV; m_armed = 0; m_bd = 0;
        m_thr = 0; m_com = 2'b00; m_enreq = 1; m_tmo = 0;
        m_en = 4'hF; m_pend = 0; m_txr = 0; m_txf = 0; m_rxe = 0;
        m_phase = 0; m_dwell = 0; m_done_prev = 0; m_rdata = 0; m_rvalid = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {m_tdsm, m_rdsm, m_stg};
            3'd1: return m_dstg[7:0];
            3'd2: return m_dstg[15:8];
            3'd3: return {m_txf, m_rxe, m_thr};
            3'd4: return {m_phase == 0, |m_pend, m_com, m_enreq, m_phase != 0, m_tmo, 1'b0};
            3'd5: return {m_en, m_pend};
            3'd6: return rx_fifo_empty_i ? 8'h00 : rx_data_i;
            default: return m_txr;
        endcase
    endfunction

    task automatic drive_idle();
        write_i = 0; read_i = 0; address_i = 0; wdata_i = 0;
        cfg_ack_i = 0; cfg_done_i = 0; tx_idle_i = 1; rx_idle_i = 1;
        tx_fifo_full_i = 0; rx_fifo_empty_i = 0; rx_data_i = 0; int_event_i = 0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        logic wr, rd, rise, stdc;
        logic [7:0] rv;
        logic [3:0] clr;
        int old_phase;
        #1;
        wr = write_i;
        rd = read_i & ~write_i;
        check("cfg_req", 32'(cfg_req_o), 32'(m_phase == 1));
        check("rx_pop", 32'(rx_fifo_read_o), 32'(rd && address_i == 3'd6 && !rx_fifo_empty_i));
        check("tx_push", 32'(tx_fifo_write_o), 32'(wr && address_i == 3'd7 && !tx_fifo_full_i));
        check("tx_data", 32'(tx_data_o), 32'(wdata_i));
        rv = model_read(address_i);

        rise = cfg_done_i && !m_done_prev;
        m_done_prev = cfg_done_i;
        stdc = wr && address_i == 3'd4 && wdata_i[0];
        old_phase = m_phase;
        m_bd = 0;
        if (wr && address_i == 3'd4) begin
            m_com = wdata_i[5:4]; m_enreq = wdata_i[3];
            if (wdata_i[1]) m_tmo = 0;
        end
        if (stdc) begin
            m_act = STD_CFG; m_stg = STD_CFG; m_phase = 0;
            m_div = STD_DIV; m_dstg = STD_DIV; m_armed = 0; m_bd = 1;
        end else begin
            if (m_phase == 0) begin
                if (wr && address_i == 3'd0) begin
                    if (m_enreq && wdata_i[5:0] != m_stg) m_phase = 1;
                    m_stg = wdata_i[5:0];
                end
            end else if (rise && (m_phase == 2 || cfg_ack_i)) begin
                m_act = m_stg; m_phase = 0;
            end else if (m_phase == 1 && cfg_ack_i) begin
                m_phase = 2;
`ifdef CONFIG_TIMEOUT_EN
            end else if (m_dwell + 1 == TMO_CYC) begin
                m_stg = m_act; m_phase = 0; m_tmo = 1;
`endif
            end
            if (wr && address_i == 3'd1) begin
                m_dstg[7:0] = wdata_i;
            end else if (wr && address_i == 3'd2) begin
                m_dstg[15:8] = wdata_i; m_armed = 1;
            end else if (m_armed && tx_idle_i && rx_idle_i) begin
                m_div = m_dstg; m_armed = 0; m_bd = 1;
            end
        end
        if (m_phase != old_phase) m_dwell = 0;
        else if (m_phase != 0) m_dwell++;
        if (wr && address_i == 3'd0) begin m_tdsm = wdata_i[7]; m_rdsm = wdata_i[6]; end
        if (wr && address_i == 3'd3) m_thr = wdata_i[5:0];
        m_txf = tx_fifo_full_i; m_rxe = rx_fifo_empty_i;
        clr = (wr && address_i == 3'd5) ? wdata_i[3:0] : 4'h0;
        m_pend = (m_pend & ~clr) | (int_event_i & m_en);
        if (wr && address_i == 3'd5) m_en = wdata_i[7:4];
        if (wr && address_i == 3'd7) m_txr = wdata_i;
        m_rdata = rd ? rv : 8'h00;
        m_rvalid = rd;

        @(posedge clk); #1;
        check("rdata", 32'(rdata_o), 32'(m_rdata));
        check("rvalid", 32'(rdata_valid_o), 32'(m_rvalid));
        check("data_width", 32'(data_width_o), 32'(m_act[1:0]));
        check("parity", 32'(parity_mode_o), 32'(m_act[3:2]));
        check("stop", 32'(stop_bits_o), 32'(m_act[5:4]));
        check("dsm", 32'({tx_dsm_o, rx_dsm_o}), 32'({m_tdsm, m_rdsm}));
        check("divisor", 32'(divisor_o), 32'(m_div));
        check("bd_reset", 32'(bd_gen_reset_o), 32'(m_bd));
        check("threshold", 32'(rx_fifo_threshold_o), 32'(m_thr));
        check("comm_mode", 32'(comm_mode_o), 32'(m_com));
        check("int", 32'(int_o), 32'(|m_pend));
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        write_i = 1; read_i = 0; address_i = a; wdata_i = d;
        step();
        write_i = 0;
    endtask

    task automatic rd_reg(input logic [2:0] a);
        write_i = 0; read_i = 1; address_i = a;
        step();
        read_i = 0;
    endtask

    initial begin
        logic [7:0] exp_rst [8];
        int nreq, n;
        exp_rst = '{8'h03, 8'h45, 8'h01, 8'h00, 8'h88, 8'hF0, 8'h00, 8'h00};
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", 32'(rdata_o), 32'h0);
        check("rst_rvalid", 32'(rdata_valid_o), 32'h0);
        check("rst_req", 32'(cfg_req_o), 32'h0);
        check("rst_bd", 32'(bd_gen_reset_o), 32'h0);
        check("rst_div", 32'(divisor_o), 32'(STD_DIV));
        check("rst_cfg", 32'({stop_bits_o, parity_mode_o, data_width_o}), 32'(STD_CFG));
        check("rst_int", 32'(int_o), 32'h0);
        rst_n = 1;

        for (int a = 0; a < 8; a++) begin
            rd_reg(3'(a));
            check("rst_read", 32'(rdata_o), 32'(exp_rst[a]));
        end

        tx_idle_i = 0;
        wr_reg(3'd1, 8'h10);
        wr_reg(3'd2, 8'h02);
        for (int i = 0; i < 5; i++) begin
            step();
            check("div_hold", 32'(divisor_o), 32'(STD_DIV));
        end
        tx_idle_i = 1;
        step();
        check("div_commit", 32'(divisor_o), 32'h0210);
        check("bd_pulse", 32'(bd_gen_reset_o), 32'h1);
        step();
        check("bd_single", 32'(bd_gen_reset_o), 32'h0);

        wr_reg(3'd0, 8'h00);
        nreq = 0;
        for (int i = 0; i < 16; i++) begin
            nreq += int'(cfg_req_o);
            if (i <= 12) check("dw_before_done", 32'(data_width_o), 32'h3);
            cfg_ack_i = (i == 2);
            cfg_done_i = (i == 12);
            write_i = (i == 5); address_i = 3'd0; wdata_i = 8'h01;
            step();
        end
        write_i = 0; cfg_ack_i = 0; cfg_done_i = 0;
        check("req_cycles", 32'(nreq), 32'd3);
        check("dw_after_done", 32'(data_width_o), 32'h0);
        rd_reg(3'd0);
        check("str_busy_ignored", 32'(rdata_o), 32'h00);

        int_event_i = 4'b0010; step(); int_event_i = 0;
        check("isr_set_int", 32'(int_o), 32'h1);
        rd_reg(3'd5);
        check("isr_read", 32'(rdata_o), 32'hF2);
        int_event_i = 4'b0010; wr_reg(3'd5, 8'hF2); int_event_i = 0;
        rd_reg(3'd5);
        check("isr_set_wins", 32'(rdata_o), 32'hF2);
        wr_reg(3'd5, 8'hF2);
        check("isr_clear", 32'(int_o), 32'h0);

        tx_fifo_full_i = 1; write_i = 1; address_i = 3'd7; wdata_i = 8'hA5;
        #1 check("txr_full_push", 32'(tx_fifo_write_o), 32'h0);
        step();
        write_i = 0; tx_fifo_full_i = 0;
        rx_fifo_empty_i = 1; rx_data_i = 8'h5A; read_i = 1; address_i = 3'd6;
        #1 check("rxr_empty_pop", 32'(rx_fifo_read_o), 32'h0);
        step();
        read_i = 0; rx_fifo_empty_i = 0;
        check("rxr_empty_data", 32'(rdata_o), 32'h00);
        rd_reg(3'd6);
        check("rxr_data", 32'(rdata_o), 32'h5A);

        wr_reg(3'd0, 8'h05);
        cfg_ack_i = 1; step(); cfg_ack_i = 0;
        wr_reg(3'd4, 8'h09);
        check("stdc_req", 32'(cfg_req_o), 32'h0);
        check("stdc_dw", 32'(data_width_o), 32'h3);
        check("stdc_bd", 32'(bd_gen_reset_o), 32'h1);
        check("stdc_div", 32'(divisor_o), 32'(STD_DIV));
        rd_reg(3'd4);
        check("stdc_ctr", 32'(rdata_o), 32'h88);

`ifdef CONFIG_TIMEOUT_EN
        wr_reg(3'd0, 8'h01);
        n = 0;
        while (cfg_req_o && n < TMO_CYC + 8) begin
            step();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO_CYC));
        rd_reg(3'd4);
        check("tmo_flag", 32'(rdata_o[1]), 32'h1);
`else
        n = 0;
`endif

        for (int i = 0; i < 4000; i++) begin
            write_i = ($urandom_range(0, 3) == 0);
            read_i = ($urandom_range(0, 2) == 0);
            address_i = 3'($urandom);
            wdata_i = 8'($urandom);
            cfg_ack_i = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) cfg_done_i = ~cfg_done_i;
            tx_idle_i = ($urandom_range(0, 3) != 0);
            rx_idle_i = ($urandom_range(0, 3) != 0);
            tx_fifo_full_i = ($urandom_range(0, 3) == 0);
            rx_fifo_empty_i = ($urandom_range(0, 3) == 0);
            rx_data_i = 8'($urandom);
            int_event_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
